// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
//   Byte FIFO and send sequencer placed in front of the UART transmitter.
//   Bytes from the core's write port are queued, up to DEPTH of them. The
//   sequencer hands one byte at a time to the transmitter: it loads
//   o_tx_data, pulses o_tx_send for one cycle, and then waits for a rising
//   edge on i_tx_finish before it releases the next byte. o_tx_data stays
//   stable for the whole frame because the transmitter computes parity from
//   its live data input.
//
// Optional feature: define UART_TX_BUFFER_OVERFLOW_EN to build a sticky
//   overflow flag that records writes dropped while the FIFO is full. With
//   the macro undefined, o_overflow is tied low.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   i_wr_en      in   write strobe, one byte per cycle
//   i_wr_data    in   [7:0] byte to enqueue
//   o_full       out  count == DEPTH
//   o_empty      out  count == 0
//   o_count      out  [ADDR_W:0] bytes queued, not counting the byte in flight
//   o_tx_data    out  [7:0] registered byte to the transmitter
//   o_tx_send    out  one-cycle send pulse
//   i_tx_finish  in   transmitter finish flag (level, cleared by the next send)
//   o_busy       out  sequencer not idle
//   o_overflow   out  sticky dropped-write flag
module uart_tx_buffer #(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_en,
  input  logic [7:0]      i_wr_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [ADDR_W:0] o_count,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_send,
  input  logic            i_tx_finish,
  output logic            o_busy,
  output logic            o_overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        tx_data_q;
  logic              finish_q;
  logic              wr_accept, pop, fin_evt;

  assign o_full    = (count_q == FULL_CNT);
  assign o_empty   = (count_q == '0);
  assign o_count   = count_q;
  assign o_tx_data = tx_data_q;
  assign o_tx_send = (state_q == S_SEND);
  assign o_busy    = (state_q != S_IDLE);

  // Judged on the registered full flag, so a write while full is dropped
  // even when the sequencer pops in the same cycle.
  assign wr_accept = i_wr_en & ~o_full;

  // Only a 0->1 rise counts; a flag still high from the previous frame
  // when WAIT is entered is not a finish.
  assign fin_evt = i_tx_finish & ~finish_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!o_empty) begin
          pop     = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND:  state_d = S_WAIT;
      S_WAIT:  if (fin_evt) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= 8'h00;
      finish_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      finish_q <= i_tx_finish;
      if (wr_accept) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
        tx_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

`ifdef UART_TX_BUFFER_OVERFLOW_EN
  logic overflow_q;
  always_ff @(posedge clk) begin
    if (rst)                  overflow_q <= 1'b0;
    else if (i_wr_en & o_full) overflow_q <= 1'b1;
  end
  assign o_overflow = overflow_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer (DEPTH = 8). A per-cycle vector table
// covers reset, single frames, stale/ignored finish flags, and a write
// coinciding with a pop. Hand-written sequences cover the long single-byte
// frame, the burst/full/overflow/drain path, and reset in the middle of a frame.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_tx_finish = 1'b0;
  logic       o_full, o_empty, o_tx_send, o_busy, o_overflow;
  logic [3:0] o_count;
  logic [7:0] o_tx_data;

  uart_tx_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_tx_data(o_tx_data), .o_tx_send(o_tx_send), .i_tx_finish(i_tx_finish),
    .o_busy(o_busy), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

`ifdef UART_TX_BUFFER_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Captures every transmitted byte while enabled.
  logic       mon_en = 1'b0;
  logic [7:0] sent [$];
  always @(negedge clk) if (mon_en && o_tx_send) sent.push_back(o_tx_data);

  typedef struct {
    logic       r, w;
    logic [7:0] d;
    logic       f;
    logic [3:0] cnt;
    logic       emp, ful, snd, bsy;
    logic [7:0] txd;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic f);
    rst = r; i_wr_en = w; i_wr_data = d; i_tx_finish = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    int  k;
    logic seen;

    //            rst   wr    data   fin   cnt   emp   ful   snd   bsy   txd
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[5]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A};
    tbl[12] = '{1'b0, 1'b1, 8'h33, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
    tbl[13] = '{1'b0, 1'b1, 8'h44, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44};
    tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44};
    tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44};
    tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44};

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].f);
      chk($sformatf("vec%0d count", i), 32'(o_count),   32'(tbl[i].cnt));
      chk($sformatf("vec%0d empty", i), 32'(o_empty),   32'(tbl[i].emp));
      chk($sformatf("vec%0d full", i),  32'(o_full),    32'(tbl[i].ful));
      chk($sformatf("vec%0d send", i),  32'(o_tx_send), 32'(tbl[i].snd));
      chk($sformatf("vec%0d busy", i),  32'(o_busy),    32'(tbl[i].bsy));
      chk($sformatf("vec%0d data", i),  32'(o_tx_data), 32'(tbl[i].txd));
      chk($sformatf("vec%0d ovf", i),   32'(o_overflow), 32'(1'b0));
    end

    // Single byte with a long frame: write at N, finish drops at N+3 and
    // rises at N+40; the step for cycle c shows cycle c+1's outputs.
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 46; c++) begin
      step(1'b0, (c == 0), 8'hA5, (c < 3) ? 1'b1 : ((c < 40) ? 1'b0 : 1'b1));
      chk($sformatf("single c%0d send", c + 1), 32'(o_tx_send), 32'(c + 1 == 2));
      chk($sformatf("single c%0d busy", c + 1), 32'(o_busy), 32'((c + 1 >= 2) && (c + 1 <= 40)));
      if (c + 1 >= 2) chk($sformatf("single c%0d data", c + 1), 32'(o_tx_data), 32'(8'hA5));
    end

    // Burst of nine bytes with finish held stale-high so the FSM parks in
    // WAIT after the first pop; this fills the FIFO, then a write of FF
    // must be dropped. Draining then yields 01..09 exactly once each.
    step(1'b1, 1'b0, 8'h00, 1'b1);
    sent.delete();
    mon_en = 1'b1;
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, 8'(i), 1'b1);
    chk("burst count", 32'(o_count), 32'd8);
    chk("burst full",  32'(o_full),  32'd1);
    chk("burst busy",  32'(o_busy),  32'd1);
    chk("pre-ovf flag", 32'(o_overflow), 32'd0);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    chk("ovf count", 32'(o_count), 32'd8);
    chk("ovf full",  32'(o_full),  32'd1);
    chk("ovf flag",  32'(o_overflow), 32'(OVF_EXP));
    k = 0;
    while (!(o_empty && !o_busy) && k < 400) begin
      step(1'b0, 1'b0, 8'h00, ((k % 8) >= 4));
      k++;
    end
    mon_en = 1'b0;
    chk("drain timeout", 32'(k < 400), 32'd1);
    chk("drain sends", 32'(sent.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      b = (i < sent.size()) ? sent[i] : 8'hxx;
      chk($sformatf("drain byte%0d", i), 32'(b), 32'(i + 1));
    end
    chk("ovf sticky", 32'(o_overflow), 32'(OVF_EXP));

    // Reset while in WAIT with three bytes queued.
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h11, 1'b1);
    step(1'b0, 1'b1, 8'h22, 1'b1);
    step(1'b0, 1'b1, 8'h33, 1'b1);
    step(1'b0, 1'b1, 8'h44, 1'b1);
    chk("midrst queued", 32'(o_count), 32'd3);
    chk("midrst busy",   32'(o_busy),  32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("midrst count", 32'(o_count),   32'd0);
    chk("midrst empty", 32'(o_empty),   32'd1);
    chk("midrst busy0", 32'(o_busy),    32'd0);
    chk("midrst data",  32'(o_tx_data), 32'd0);
    chk("midrst ovf",   32'(o_overflow), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b0, 8'h00, c[0]);
      if (o_tx_send) seen = 1'b1;
    end
    chk("midrst no send", 32'(seen), 32'd0);
    chk("midrst idle", 32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
